// File: rtl/centroid_reader_if.sv
// centroid_reader_if: data-table read port plus valid/ready record stream
interface centroid_reader_if #(
  parameter int WORD_SIZE = 8,
  parameter int OBJ_WIDTH = 16,
  parameter int LOC_SIZE  = 16
);
  logic [WORD_SIZE-1:0]   obj_id;
  logic [3*OBJ_WIDTH-1:0] data_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_SIZE-1:0]   out_label;
  logic [OBJ_WIDTH-1:0]   out_area;
  logic [LOC_SIZE-1:0]    out_x;
  logic [LOC_SIZE-1:0]    out_y;
  modport master (
    output obj_id, out_valid, out_label, out_area, out_x, out_y,
    input  data_in, out_ready
  );
  modport slave (
    input  obj_id, out_valid, out_label, out_area, out_x, out_y,
    output data_in, out_ready
  );
endinterface

// File: rtl/centroid_reader.sv
// centroid_reader: walks the per-label object table, divides accumulators by area
// and streams one centroid record per non-empty label.
module centroid_reader #(
  parameter int WORD_SIZE = 8,
  parameter int OBJ_WIDTH = 16,
  parameter int LOC_SIZE  = 16,
  parameter int MIN_AREA  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [WORD_SIZE-1:0] num_labels_i,
  output logic                 busy_o,
  output logic                 done_o,
  centroid_reader_if.master    bus
);
  localparam int CW = $clog2(OBJ_WIDTH + 1);
  localparam logic [WORD_SIZE-1:0] ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OBJ_WIDTH - 1);
  localparam logic [OBJ_WIDTH-1:0] MIN_A = OBJ_WIDTH'(MIN_AREA);
  typedef enum logic [2:0] {IDLE, ADDR, READ, DIV, OUT, FIN} state_t;
  state_t state_q, state_d;
  logic [WORD_SIZE-1:0] idx_q, idx_d, lim_q, lim_d, idx_inc;
  logic [OBJ_WIDTH-1:0] area_q, area_d, qx_q, qx_d, qy_q, qy_d, rx_q, rx_d, ry_q, ry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*OBJ_WIDTH-1:0] step_x, step_y;
  logic [LOC_SIZE+OBJ_WIDTH-1:0] ext_x, ext_y;
  logic last;
  // One restoring-division step on {remainder, quotient/dividend shift register}
  function automatic logic [2*OBJ_WIDTH-1:0] div_step(
    input logic [OBJ_WIDTH-1:0] r,
    input logic [OBJ_WIDTH-1:0] q,
    input logic [OBJ_WIDTH-1:0] d
  );
    logic [OBJ_WIDTH:0] s;
    logic [OBJ_WIDTH:0] t;
    s = {r, q[OBJ_WIDTH-1]};
    t = s - {1'b0, d};
    return (s >= {1'b0, d}) ? {t[OBJ_WIDTH-1:0], q[OBJ_WIDTH-2:0], 1'b1}
                            : {s[OBJ_WIDTH-1:0], q[OBJ_WIDTH-2:0], 1'b0};
  endfunction
  assign step_x  = div_step(rx_q, qx_q, area_q);
  assign step_y  = div_step(ry_q, qy_q, area_q);
  assign idx_inc = idx_q + ONE;
  assign last    = idx_inc == lim_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lim_q   <= '0;
      area_q  <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lim_q   <= lim_d;
      area_q  <= area_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lim_d   = lim_q;
    area_d  = area_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        lim_d   = num_labels_i;
        idx_d   = ONE;
        state_d = (num_labels_i <= ONE) ? FIN : ADDR;
      end
      ADDR: state_d = READ;
      READ: begin
        area_d = bus.data_in[OBJ_WIDTH-1:0];
        qx_d   = bus.data_in[2*OBJ_WIDTH-1:OBJ_WIDTH];
        qy_d   = bus.data_in[3*OBJ_WIDTH-1:2*OBJ_WIDTH];
        rx_d   = '0;
        ry_d   = '0;
        cnt_d  = '0;
        if (bus.data_in[OBJ_WIDTH-1:0] < MIN_A) begin
          idx_d   = idx_inc;
          state_d = last ? FIN : ADDR;
        end else state_d = DIV;
      end
      DIV: begin
        {rx_d, qx_d} = step_x;
        {ry_d, qy_d} = step_y;
        cnt_d   = cnt_q + CNT_ONE;
        state_d = (cnt_q == CNT_LAST) ? OUT : DIV;
      end
      OUT: if (bus.out_ready) begin
        idx_d   = idx_inc;
        state_d = last ? FIN : ADDR;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Zero-extend before slicing so any LOC_SIZE/OBJ_WIDTH ratio works
  assign ext_x         = {{LOC_SIZE{1'b0}}, qx_q};
  assign ext_y         = {{LOC_SIZE{1'b0}}, qy_q};
  assign bus.obj_id    = idx_q;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_label = idx_q;
  assign bus.out_area  = area_q;
  assign bus.out_x     = ext_x[LOC_SIZE-1:0];
  assign bus.out_y     = ext_y[LOC_SIZE-1:0];
  assign busy_o        = state_q != IDLE;
  assign done_o        = state_q == FIN;
endmodule

// File: tb/tb_centroid_reader.sv
// tb_centroid_reader: directed checks of the centroid table walker
module tb_centroid_reader;
  logic clk = 0;
  logic reset_n = 0;
  logic start = 0;
  logic [7:0] num_labels = 0;
  logic busy, done;
  logic [47:0] mem [256];
  int checks = 0;
  int passes = 0;
  int n;
  logic [15:0] h_area, h_x, h_y;
  centroid_reader_if #(.WORD_SIZE(8), .OBJ_WIDTH(16), .LOC_SIZE(16)) bus ();
  centroid_reader #(.WORD_SIZE(8), .OBJ_WIDTH(16), .LOC_SIZE(16), .MIN_AREA(1)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .num_labels_i(num_labels),
    .busy_o(busy), .done_o(done), .bus(bus)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) bus.data_in <= mem[bus.obj_id];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic go(input logic [7:0] lim);
    num_labels = lim;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic rec(input string tag, input logic [7:0] l, input logic [15:0] a,
                     input logic [15:0] x, input logic [15:0] y);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_label"}, 32'(bus.out_label), 32'(l));
    chk({tag, "_area"}, 32'(bus.out_area), 32'(a));
    chk({tag, "_x"}, 32'(bus.out_x), 32'(x));
    chk({tag, "_y"}, 32'(bus.out_y), 32'(y));
    tick();
  endtask
  task automatic fin(input string tag);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_novalid"}, 32'(bus.out_valid), 0);
    tick();
    chk({tag, "_done_drop"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.out_ready = 1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_obj_id", 32'(bus.obj_id), 0);
    chk("rst_label", 32'(bus.out_label), 0);
    reset_n = 1;
    tick();
    // basic record and ADDR-to-valid latency
    mem[1] = {16'd20, 16'd40, 16'd4};
    go(8'd2);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("lat", 32'(n), 19);
    chk("t1_busy", 32'(busy), 1);
    rec("t1", 8'd1, 16'd4, 16'd10, 16'd5);
    fin("t1");
    // truncation and full-range quotient
    mem[1] = {16'd7, 16'd10, 16'd3};
    mem[2] = {16'd0, 16'd65535, 16'd1};
    go(8'd3);
    rec("t2a", 8'd1, 16'd3, 16'd3, 16'd2);
    rec("t2b", 8'd2, 16'd1, 16'd65535, 16'd0);
    fin("t2");
    // empty label skipped
    mem[1] = {16'd50, 16'd25, 16'd5};
    mem[2] = {16'd9, 16'd9, 16'd0};
    mem[3] = {16'd7, 16'd9, 16'd2};
    go(8'd4);
    rec("t3a", 8'd1, 16'd5, 16'd5, 16'd10);
    rec("t3b", 8'd3, 16'd2, 16'd4, 16'd3);
    fin("t3");
    for (int i = 0; i < 4; i++) tick();
    chk("t3_single_done", 32'(done), 0);
    // backpressure
    mem[1] = {16'd33, 16'd100, 16'd7};
    bus.out_ready = 0;
    go(8'd2);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    h_area = bus.out_area;
    h_x = bus.out_x;
    h_y = bus.out_y;
    chk("t4_x", 32'(h_x), 14);
    chk("t4_y", 32'(h_y), 4);
    chk("t4_area", 32'(h_area), 7);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(bus.out_valid), 1);
      chk("t4_hold_label", 32'(bus.out_label), 1);
      chk("t4_hold_x", 32'(bus.out_x), 32'(h_x));
      chk("t4_hold_y", 32'(bus.out_y), 32'(h_y));
      chk("t4_hold_area", 32'(bus.out_area), 32'(h_area));
      chk("t4_hold_obj_id", 32'(bus.obj_id), 1);
      tick();
    end
    chk("t4_still_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1;
    tick();
    fin("t4");
    // empty frame
    go(8'd1);
    fin("t5_empty");
    // second start mid-walk ignored, lim stays latched
    mem[1] = {16'd10, 16'd20, 16'd10};
    mem[2] = {16'd0, 16'd0, 16'd1};
    mem[3] = {16'd255, 16'd256, 16'd16};
    go(8'd4);
    tick();
    tick();
    go(8'd2);
    rec("t5a", 8'd1, 16'd10, 16'd2, 16'd1);
    rec("t5b", 8'd2, 16'd1, 16'd0, 16'd0);
    rec("t5c", 8'd3, 16'd16, 16'd16, 16'd15);
    fin("t5");
    // asynchronous reset while dividing
    mem[1] = {16'd20, 16'd40, 16'd4};
    go(8'd2);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_busy_pre", 32'(busy), 1);
    reset_n = 0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    tick();
    chk("t6_rst_done_hold", 32'(done), 0);
    reset_n = 1;
    tick();
    go(8'd2);
    rec("t6", 8'd1, 16'd4, 16'd10, 16'd5);
    fin("t6");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
